// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: strips E0/F0 prefixes, builds key events
// {ext, brk, code}, and queues them in a small first-word-fall-through FIFO.
// A gap watchdog abandons sequences whose bytes arrive too far apart.
module ps2_key_decoder #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset1,
   input  logic [7:0] byte_i,
   input  logic       byte_valid_i,
   output logic [7:0] ev_code_o,
   output logic       ev_ext_o,
   output logic       ev_break_o,
   output logic       ev_valid_o,
   input  logic       ev_pop_i,
   output logic       overflow_o
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_E0   = 2'd1;
   localparam logic [1:0] S_F0   = 2'd2;
   localparam logic [1:0] S_E0F0 = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] wd_q, wd_d;
   logic          emit;
   logic          ev_ext, ev_brk;
   logic          is_ctrl;

   logic [FIFO_DEPTH-1:0][9:0] mem_q;
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q;
   logic          ovf_q;
   logic          full, do_pop, do_push;

   // Bytes that never form part of a key sequence (acks, BAT, echo, pause lead-in)
   always_comb begin
      unique case (byte_i)
         8'h00, 8'hFF, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hE1: is_ctrl = 1'b1;
         default:                                                is_ctrl = 1'b0;
      endcase
   end

   // Prefix FSM and watchdog next state; a byte beats a same-cycle timeout
   always_comb begin
      state_d = state_q;
      emit    = 1'b0;
      ev_ext  = 1'b0;
      ev_brk  = 1'b0;
      if (byte_valid_i) begin
         if (is_ctrl) begin
            state_d = S_IDLE;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (byte_i == 8'hE0)      state_d = S_E0;
                  else if (byte_i == 8'hF0) state_d = S_F0;
                  else                      emit = 1'b1;
               end
               S_E0: begin
                  if (byte_i == 8'hF0)      state_d = S_E0F0;
                  else if (byte_i != 8'hE0) begin
                     emit = 1'b1; ev_ext = 1'b1; state_d = S_IDLE;
                  end
               end
               S_F0: begin
                  if (byte_i == 8'hE0)      state_d = S_E0F0;
                  else if (byte_i != 8'hF0) begin
                     emit = 1'b1; ev_brk = 1'b1; state_d = S_IDLE;
                  end
               end
               default: begin
                  if (byte_i != 8'hE0 && byte_i != 8'hF0) begin
                     emit = 1'b1; ev_ext = 1'b1; ev_brk = 1'b1; state_d = S_IDLE;
                  end
               end
            endcase
         end
      end else if (state_q != S_IDLE && wd_q == TO_MAX) begin
         state_d = S_IDLE;
      end

      if (byte_valid_i || state_q == S_IDLE || wd_q == TO_MAX) wd_d = '0;
      else                                                     wd_d = wd_q + 1'b1;
   end

   // FSM and watchdog registers
   always_ff @(posedge clk or negedge reset1) begin
      if (!reset1) begin
         state_q <= S_IDLE;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
      end
   end

   assign full    = (cnt_q == FULL_CNT);
   assign do_pop  = ev_pop_i && (cnt_q != '0);
   // When full, a push only fits if the head leaves in the same cycle
   assign do_push = emit && (!full || do_pop);

   // Event FIFO storage, pointers, count and sticky overflow flag
   always_ff @(posedge clk or negedge reset1) begin
      if (!reset1) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= {ev_ext, ev_brk, byte_i};
            wptr_q        <= wptr_q + 1'b1;
         end
         if (do_pop) rptr_q <= rptr_q + 1'b1;
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
         if (emit && !do_push) ovf_q <= 1'b1;
      end
   end

   assign ev_valid_o = (cnt_q != '0);
   assign ev_ext_o   = mem_q[rptr_q][9];
   assign ev_break_o = mem_q[rptr_q][8];
   assign ev_code_o  = mem_q[rptr_q][7:0];
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: prefix decoding, control-byte discard,
// watchdog timeout, FIFO ordering/overflow and asynchronous reset.
module tb_ps2_key_decoder;

   logic       clk = 1'b0;
   logic       reset1;
   logic [7:0] byte_i;
   logic       byte_valid_i;
   logic [7:0] ev_code_o;
   logic       ev_ext_o, ev_break_o, ev_valid_o, ev_pop_i, overflow_o;

   int checks = 0;
   int errors = 0;

   ps2_key_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset1(reset1), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
      .ev_code_o(ev_code_o), .ev_ext_o(ev_ext_o), .ev_break_o(ev_break_o),
      .ev_valid_o(ev_valid_o), .ev_pop_i(ev_pop_i), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; strobes one byte for exactly one rising edge
   task automatic send(input logic [7:0] b);
      byte_i = b; byte_valid_i = 1'b1;
      @(negedge clk);
      byte_valid_i = 1'b0;
   endtask

   task automatic pop();
      ev_pop_i = 1'b1;
      @(negedge clk);
      ev_pop_i = 1'b0;
   endtask

   // Head event check: valid plus {ext, brk, code}
   task automatic chk_ev(input string tag, input logic [7:0] c, input logic e, input logic b);
      chk({tag, "_valid"}, {9'd0, ev_valid_o}, 10'd1);
      chk({tag, "_event"}, {ev_ext_o, ev_break_o, ev_code_o}, {e, b, c});
   endtask

   initial begin
      reset1 = 1'b0; byte_i = 8'h00; byte_valid_i = 1'b0; ev_pop_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", {9'd0, ev_valid_o}, 10'd0);
      chk("rst_event", {ev_ext_o, ev_break_o, ev_code_o}, 10'h000);
      chk("rst_ovf", {9'd0, overflow_o}, 10'd0);
      reset1 = 1'b1;
      @(negedge clk);

      // Plain make code, one-cycle latency, pop empties
      send(8'h1C);
      chk_ev("make1C", 8'h1C, 1'b0, 1'b0);
      pop();
      chk("pop_empty", {9'd0, ev_valid_o}, 10'd0);

      // Extended break: E0 F0 74
      send(8'hE0);
      chk("e0_noev", {9'd0, ev_valid_o}, 10'd0);
      send(8'hF0);
      chk("e0f0_noev", {9'd0, ev_valid_o}, 10'd0);
      send(8'h74);
      chk_ev("extbrk74", 8'h74, 1'b1, 1'b1);
      pop();
      chk("extbrk_one", {9'd0, ev_valid_o}, 10'd0);

      // Control byte aborts a break prefix
      send(8'hF0);
      send(8'hAA);
      chk("aa_noev", {9'd0, ev_valid_o}, 10'd0);
      send(8'h1C);
      chk_ev("aa_make", 8'h1C, 1'b0, 1'b0);
      pop();

      // Pause lead-in E1 is dropped, next byte is an ordinary make
      send(8'hE1);
      send(8'h14);
      chk_ev("e1_make", 8'h14, 1'b0, 1'b0);
      pop();

      // Watchdog: 16 idle edges after E0 time out the prefix
      send(8'hE0);
      repeat (16) @(negedge clk);
      send(8'h75);
      chk_ev("timeout", 8'h75, 1'b0, 1'b0);
      pop();
      // 10-cycle gap keeps the prefix
      send(8'hE0);
      repeat (10) @(negedge clk);
      send(8'h75);
      chk_ev("no_timeout", 8'h75, 1'b1, 1'b0);
      pop();
      chk("wd_empty", {9'd0, ev_valid_o}, 10'd0);
      // 15 idle edges: the byte lands on the timeout cycle and wins
      send(8'hE0);
      repeat (15) @(negedge clk);
      send(8'h6B);
      chk_ev("to_same_cycle", 8'h6B, 1'b1, 1'b0);
      pop();

      // Fill past depth with back-to-back strobes
      chk("pre_fill_ovf", {9'd0, overflow_o}, 10'd0);
      for (int i = 1; i <= 5; i++) send(8'(i));
      chk("ovf_set", {9'd0, overflow_o}, 10'd1);
      chk_ev("full_head", 8'h01, 1'b0, 1'b0);

      // Full: simultaneous push and pop, no drop
      byte_i = 8'h06; byte_valid_i = 1'b1; ev_pop_i = 1'b1;
      @(negedge clk);
      byte_valid_i = 1'b0; ev_pop_i = 1'b0;
      chk_ev("pp_head", 8'h02, 1'b0, 1'b0);
      pop();
      chk_ev("rd03", 8'h03, 1'b0, 1'b0);
      pop();
      chk_ev("rd04", 8'h04, 1'b0, 1'b0);
      pop();
      chk_ev("rd06", 8'h06, 1'b0, 1'b0);
      pop();
      chk("drain_empty", {9'd0, ev_valid_o}, 10'd0);
      chk("ovf_sticky", {9'd0, overflow_o}, 10'd1);

      // Async reset with FIFO non-empty and a prefix pending
      send(8'h33);
      send(8'hE0);
      #2 reset1 = 1'b0;
      #1;
      chk("arst_valid", {9'd0, ev_valid_o}, 10'd0);
      chk("arst_event", {ev_ext_o, ev_break_o, ev_code_o}, 10'h000);
      chk("arst_ovf", {9'd0, overflow_o}, 10'd0);
      @(negedge clk);
      reset1 = 1'b1;
      @(negedge clk);
      send(8'h44);
      chk_ev("post_rst", 8'h44, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Downstream consumer of the PS/2 serial receive stage. Takes each completed 8-bit scan-code byte from the receiver, strips Set-2 prefix bytes (0xE0 extended, 0xF0 break), and turns each complete sequence into one key event (code, extended flag, break flag). Events are queued in a small first-word-fall-through FIFO with a valid/pop handshake for the display or control logic further down. A gap watchdog discards half-received sequences.

## Interface
- FIFO_DEPTH, 4: event FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 100000: maximum clk cycles allowed between bytes of one multi-byte sequence (1 ms at 100 MHz).

- clk  in  1  system clock; all logic on rising edge.
- reset1  in  1  asynchronous, active-low reset.
- byte_i  in  8  scan byte from the serial receiver; sampled only when byte_valid_i=1.
- byte_valid_i  in  1  one-cycle strobe, one per received byte.
- ev_code_o  out  8  key code of the FIFO head entry.
- ev_ext_o  out  1  head entry was E0-prefixed.
- ev_break_o  out  1  head entry is a release (F0-prefixed).
- ev_valid_o  out  1  FIFO non-empty; the ev_* outputs are meaningful.
- ev_pop_i  in  1  consumer removes the head entry this cycle.
- overflow_o  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Prefix FSM with states IDLE, E0, F0 and E0F0. It acts only on cycles with byte_valid_i=1.
- Control bytes 0x00, 0xFF, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE and 0xE1, in any state: no event is produced; the FSM moves to IDLE.
- IDLE: 0xE0 goes to E0; 0xF0 goes to F0; any other byte emits {code, ext=0, brk=0}.
- E0: 0xF0 goes to E0F0; 0xE0 stays in E0; any other byte emits {code, 1, 0} and returns to IDLE.
- F0: 0xE0 goes to E0F0; 0xF0 stays in F0; any other byte emits {code, 0, 1} and returns to IDLE.
- E0F0: 0xE0 or 0xF0 stays in E0F0; any other byte emits {code, 1, 1} and returns to IDLE.
- Pause (E1 …) is not decoded. E1 is discarded; the following bytes decode as ordinary sequences.
- Watchdog counter, width clog2(TIMEOUT_CYCLES):
  - Cleared while the FSM is in IDLE and on every byte_valid_i.
  - Increments every cycle otherwise.
  - On reaching TIMEOUT_CYCLES-1 the FSM is forced to IDLE, no event is emitted, and the counter clears.
  - A byte arriving in the same cycle as the timeout takes priority and is decoded in the pre-timeout state.
- FIFO entry is 10 bits {ext, brk, code}. Circular read/write pointers plus a count, all wrapping modulo FIFO_DEPTH.
  - Push happens on an emit.
  - Pop happens when ev_pop_i=1 and ev_valid_o=1. Pop while empty is ignored.
  - Full with push and pop in the same cycle: both happen, the count is unchanged, no overflow.
  - Full with push and no pop: the new event is dropped and overflow_o is set. overflow_o clears only on reset.
- Reset asserted mid-sequence or with the FIFO non-empty clears everything immediately: FSM to IDLE, counter 0, FIFO empty.

## Timing
- Reset values: ev_valid_o=0, ev_code_o=0x00, ev_ext_o=0, ev_break_o=0, overflow_o=0.
- Latency: with the FIFO empty, a terminating byte strobed in cycle N gives ev_valid_o=1 with the event's ev_* values in cycle N+1.
- Head outputs are registered (or driven from registered FIFO storage) and stay stable while ev_valid_o=1 and ev_pop_i=0.
- After a pop in cycle N, the next entry appears in cycle N+1. If the FIFO is then empty, ev_valid_o=0 in cycle N+1.
- Back-to-back byte_valid_i strobes on consecutive cycles are accepted. Throughput is one byte per cycle.
- overflow_o rises in the cycle after the dropped push.

## Test plan
- Reset, then byte 0x1C → next cycle ev_valid_o=1, code 0x1C, ext=0, brk=0. Pop → ev_valid_o=0 next cycle.
- Bytes E0, F0, 0x74 → exactly one event {0x74, ext=1, brk=1}; the prefixes produce no events.
- Bytes F0, AA, 0x1C → the AA is discarded and resets the FSM; one event {0x1C, 0, 0}, not a break.
- Byte E0, idle TIMEOUT_CYCLES cycles (use TIMEOUT_CYCLES=16), then 0x75 → event {0x75, 0, 0}. Repeat with a 10-cycle gap → {0x75, 1, 0}.
- FIFO_DEPTH=4: push 5 make codes 0x01–0x05 with no pops → the 4 entries read back 0x01–0x04 in order; overflow_o=1 and stays set.
- FIFO full: push 0x06 and pop in the same cycle → no overflow, count stays 4, order preserved. Then assert reset1=0 mid-sequence (after E0) → all outputs return to reset values immediately.
